// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic register pipeline.
// Sizing of the occupancy counter lives here so the top and bench agree.
package pipe_pkg;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: enable-loaded data register plus its valid bit.
// clear wins over load for the valid bit; data only changes on load.
module pipe_stage #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= RESET_DATA;
            valid <= 1'b0;
        end else begin
            if (load) begin
                q <= d;
            end
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register pipeline with valid/ready backpressure,
// bubble collapse, synchronous flush and a registered occupancy count.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 3,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [clog2_cnt(DEPTH)-1:0]   count
);

    localparam int CW = clog2_cnt(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] clear;
    logic [WIDTH-1:0] q [DEPTH];
    logic             in_hs;
    logic             out_hs;

    // A stage is ready if the next one is empty or is itself moving on.
    always_comb begin
        ready            = '0;
        ready[DEPTH-1]   = out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            ready[i] = !valid[i+1] || ready[i+1];
        end
    end

    assign adv      = valid & ready;
    assign in_ready = !reset && (!valid[0] || ready[0]) && !flush;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = valid[DEPTH-1] && out_ready;

    // Loads are suppressed on flush so every data register holds its value.
    always_comb begin
        load    = '0;
        clear   = '0;
        load[0] = in_hs;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = adv[i-1] && !flush;
        end
        for (int i = 0; i < DEPTH; i++) begin
            clear[i] = flush || (adv[i] && !load[i]);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] d;
        if (g == 0) begin : g_first
            assign d = in_data;
        end else begin : g_next
            assign d = q[g-1];
        end
        pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .load  (load[g]),
            .clear (clear[g]),
            .d     (d),
            .q     (q[g]),
            .valid (valid[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_hs && !out_hs) begin
            count <= count + CW'(1);
        end else if (!in_hs && out_hs) begin
            count <= count - CW'(1);
        end
    end

    assign out_valid = valid[DEPTH-1];
    assign out_data  = q[DEPTH-1];

    a_count_matches_valid : assert property (@(posedge clk) disable iff (reset)
        count == CW'($countones(valid)));

    a_out_stable_on_stall : assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and random stimulus for pipe_reg_chain against a word-position model:
// each word in flight moves one slot per cycle unless blocked by the word ahead.
module tb_pipe_reg_chain;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] count;

    logic       f1;
    logic       v1;
    logic [7:0] d1;
    logic       ir1;
    logic       ov1;
    logic [7:0] od1;
    logic       or1;
    logic [0:0] c1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdat [$];
    int         mpos [$];
    int         np   [$];
    bit         leaving;
    bit         exp_in_ready;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(D), .RESET_DATA(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_DATA(8'hC3)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (f1),
        .in_valid  (v1),
        .in_data   (d1),
        .in_ready  (ir1),
        .out_valid (ov1),
        .out_data  (od1),
        .out_ready (or1),
        .count     (c1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Where every word would sit after the coming edge, given the consumer's ready.
    task automatic plan(input logic ordy, input logic fl);
        int lim;
        int p;
        np.delete();
        leaving = (mpos.size() > 0) && (mpos[0] == D - 1) && ordy;
        lim = D;
        for (int k = (leaving ? 1 : 0); k < mpos.size(); k++) begin
            p = mpos[k] + 1;
            if (p > lim - 1) p = lim - 1;
            np.push_back(p);
            lim = p;
        end
        exp_in_ready = !fl && ((np.size() == 0) || (np[np.size()-1] >= 1));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        bit exp_ov;
        @(negedge clk);
        in_valid  = v;
        in_data   = v ? d : 8'hxx;
        out_ready = ordy;
        flush     = fl;
        #1;
        plan(ordy, fl);
        exp_ov = (mpos.size() > 0) && (mpos[0] == D - 1);
        chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("count", 32'(count), 32'(mpos.size()));
        if (exp_ov) chk("out_data", 32'(out_data), 32'(mdat[0]));
        @(posedge clk);
        if (leaving) begin
            void'(mdat.pop_front());
            void'(mpos.pop_front());
        end
        for (int k = 0; k < mpos.size(); k++) mpos[k] = np[k];
        if (fl) begin
            mdat.delete();
            mpos.delete();
        end else if (v && exp_in_ready) begin
            mdat.push_back(d);
            mpos.push_back(0);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        f1 = 1'b0; v1 = 1'b0; d1 = 8'h00; or1 = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // streaming
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b1, 8'h44, 1'b1, 1'b0);
        idle(4, 1'b1);

        // backpressure: fourth word refused while full and stalled
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0);
        step(1'b1, 8'hA4, 1'b0, 1'b0);
        #1;
        chk("bp_count", 32'(count), 32'd3);
        chk("bp_hold", 32'(out_data), 32'hA1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 8'hA4, 1'b1, 1'b0);
        #1;
        chk("bp_full_swap_count", 32'(count), 32'd3);
        idle(4, 1'b1);

        // bubble collapse
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        #1;
        chk("bubble_count", 32'(count), 32'd3);
        idle(4, 1'b1);

        // flush with a concurrent output handshake
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        idle(4, 1'b1);

        // asynchronous reset between edges
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'h00);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        mdat.delete();
        mpos.delete();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        idle(4, 1'b1);

        // random traffic, X data while idle
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0));
        end
        idle(4, 1'b1);

        // single-stage instance
        @(negedge clk);
        #1;
        chk("d1_rst_data", 32'(od1), 32'hC3);
        chk("d1_rst_count", 32'(c1), 32'd0);
        chk("d1_in_ready", 32'(ir1), 32'd1);
        v1 = 1'b1; d1 = 8'h10; or1 = 1'b0;
        @(negedge clk);
        v1 = 1'b1; d1 = 8'h20;
        #1;
        chk("d1_load_valid", 32'(ov1), 32'd1);
        chk("d1_load_data", 32'(od1), 32'h10);
        chk("d1_full_stall", 32'(ir1), 32'd0);
        @(negedge clk);
        chk("d1_hold_data", 32'(od1), 32'h10);
        or1 = 1'b1;
        #1;
        chk("d1_pass_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        v1 = 1'b0;
        #1;
        chk("d1_pass_data", 32'(od1), 32'h20);
        chk("d1_pass_count", 32'(c1), 32'd1);
        @(negedge clk);
        #1;
        chk("d1_drain_valid", 32'(ov1), 32'd0);
        chk("d1_drain_count", 32'(c1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
